// File: rtl/dmem_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter: read-return owner encoding,
// default bus widths and a saturating counter helper.
package dmem_arb_pkg;

  localparam int DMEM_AW = 10;
  localparam int DMEM_DW = 32;

  typedef enum logic [1:0] {
    RSEL_NONE = 2'd0,
    RSEL_CPU  = 2'd1,
    RSEL_DBG  = 2'd2
  } rsel_e;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// CPU, debug-loader and memory-side signals of the data-memory arbiter.
// slave = arbiter view; master = requesters plus the memory macro.
interface dmem_arbiter_if #(
  parameter int AW = dmem_arb_pkg::DMEM_AW,
  parameter int DW = dmem_arb_pkg::DMEM_DW
);
  logic          cpu_req;
  logic          cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic          cpu_stall;
  logic          cpu_rvalid;
  logic [DW-1:0] cpu_rdata;

  logic          dbg_req;
  logic          dbg_we;
  logic [AW-1:0] dbg_addr;
  logic [DW-1:0] dbg_wdata;
  logic          dbg_gnt;
  logic          dbg_rvalid;
  logic [DW-1:0] dbg_rdata;

  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_stall, cpu_rvalid, cpu_rdata,
    input  dbg_req, dbg_we, dbg_addr, dbg_wdata,
    output dbg_gnt, dbg_rvalid, dbg_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_stall, cpu_rvalid, cpu_rdata,
    output dbg_req, dbg_we, dbg_addr, dbg_wdata,
    input  dbg_gnt, dbg_rvalid, dbg_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/dmem_arbiter_rr_burst_pick.sv
// Grant picker: debug may win up to MAX_BURST contested cycles in a row, then CPU gets one.
// Latency: grants are combinational from requests and registered history.
// Backpressure: the loser is simply not granted; requesters hold their request.
module rr_burst_pick #(
  parameter int MAX_BURST = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic cpu_req,
  input  logic dbg_req,
  output logic cpu_grant,
  output logic dbg_grant
);

  localparam logic [3:0] BURST_LIM = 4'(MAX_BURST);

  logic       last_dbg_q, last_dbg_d;
  logic [3:0] burst_cnt_q, burst_cnt_d;
  logic       contested;
  logic       dbg_pref;

  always_comb begin
    contested   = cpu_req & dbg_req;
    dbg_pref    = ~last_dbg_q | (burst_cnt_q < BURST_LIM);
    dbg_grant   = dbg_req & (~cpu_req | dbg_pref);
    cpu_grant   = cpu_req & ~dbg_grant;

    last_dbg_d  = last_dbg_q;
    if (contested) last_dbg_d = dbg_grant;

    // Any cycle the CPU is idle or served ends the debug run.
    burst_cnt_d = '0;
    if (cpu_req & dbg_grant)
      burst_cnt_d = (burst_cnt_q >= BURST_LIM) ? BURST_LIM : burst_cnt_q + 4'd1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_dbg_q  <= 1'b0;
      burst_cnt_q <= '0;
    end else begin
      last_dbg_q  <= last_dbg_d;
      burst_cnt_q <= burst_cnt_d;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares single-port dmem between CPU and debug loader; optional DMEM_ARB_STATS_EN adds counters.
// Latency: grant combinational, write commits at grant edge, read data 1 cycle after grant.
// Backpressure: losing CPU sees cpu_stall, losing debug sees dbg_gnt=0; both must hold requests.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int AW        = DMEM_AW,
  parameter int DW        = DMEM_DW,
  parameter int MAX_BURST = 4
) (
  input  logic           clk,
  input  logic           reset,
  dmem_arbiter_if.slave  bus
`ifdef DMEM_ARB_STATS_EN
  ,
  output logic [15:0]    stat_stall,
  output logic [15:0]    stat_dbg
`endif
);

  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } req_t;

  logic  cpu_grant, dbg_grant;
  req_t  cpu_r, dbg_r, win_r;
  rsel_e rsel_q, rsel_d;

  rr_burst_pick #(.MAX_BURST(MAX_BURST)) u_pick (
    .clk       (clk),
    .reset     (reset),
    .cpu_req   (bus.cpu_req),
    .dbg_req   (bus.dbg_req),
    .cpu_grant (cpu_grant),
    .dbg_grant (dbg_grant)
  );

  assign cpu_r = {bus.cpu_we, bus.cpu_addr, bus.cpu_wdata};
  assign dbg_r = {bus.dbg_we, bus.dbg_addr, bus.dbg_wdata};

  always_comb begin
    win_r = '0;
    if (cpu_grant)      win_r = cpu_r;
    else if (dbg_grant) win_r = dbg_r;
  end

  assign bus.mem_en    = cpu_grant | dbg_grant;
  assign bus.mem_we    = win_r.we;
  assign bus.mem_addr  = win_r.addr;
  assign bus.mem_wdata = win_r.wdata;

  assign bus.cpu_stall = bus.cpu_req & ~cpu_grant;
  assign bus.dbg_gnt   = dbg_grant;

  // Owner of the read issued this cycle; its data returns next cycle.
  always_comb begin
    rsel_d = RSEL_NONE;
    if (cpu_grant & ~bus.cpu_we)      rsel_d = RSEL_CPU;
    else if (dbg_grant & ~bus.dbg_we) rsel_d = RSEL_DBG;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) rsel_q <= RSEL_NONE;
    else        rsel_q <= rsel_d;
  end

  assign bus.cpu_rvalid = (rsel_q == RSEL_CPU);
  assign bus.dbg_rvalid = (rsel_q == RSEL_DBG);
  assign bus.cpu_rdata  = bus.cpu_rvalid ? bus.mem_rdata : '0;
  assign bus.dbg_rdata  = bus.dbg_rvalid ? bus.mem_rdata : '0;

`ifdef DMEM_ARB_STATS_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stat_stall <= '0;
      stat_dbg   <= '0;
    end else begin
      if (bus.cpu_stall) stat_stall <= sat_inc16(stat_stall);
      if (dbg_grant)     stat_dbg   <= sat_inc16(stat_dbg);
    end
  end
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed vector table, reset corner cases, and random traffic
// against a reference model of the arbitration rules and a word-array memory.
module tb_dmem_arbiter;

  localparam int AW        = 10;
  localparam int DW        = 32;
  localparam int MAX_BURST = 4;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  dmem_arbiter_if #(.AW(AW), .DW(DW)) bus ();

`ifdef DMEM_ARB_STATS_EN
  logic [15:0] stat_stall, stat_dbg;
`endif

  dmem_arbiter #(.AW(AW), .DW(DW), .MAX_BURST(MAX_BURST)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
`ifdef DMEM_ARB_STATS_EN
    ,
    .stat_stall (stat_stall),
    .stat_dbg   (stat_dbg)
`endif
  );

  // Synchronous-read single-port memory seen by the arbiter.
  bit [DW-1:0] tb_mem [1024];
  always @(posedge clk) begin
    if (bus.mem_en) begin
      if (bus.mem_we) tb_mem[bus.mem_addr] <= bus.mem_wdata;
      else            bus.mem_rdata        <= tb_mem[bus.mem_addr];
    end
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: who won recently, pending read owner and the memory image.
  bit          m_last_dbg;
  int          m_streak;
  int          m_pend;
  bit [DW-1:0] m_pend_dat;
  bit [DW-1:0] ref_mem [1024];
  bit          m_cpu_hold, m_dbg_hold;

  task automatic model_reset();
    m_last_dbg = 0;
    m_streak   = 0;
    m_pend     = 0;
    m_pend_dat = '0;
    m_cpu_hold = 0;
    m_dbg_hold = 0;
  endtask

  task automatic model_step();
    bit            dw_, cw_;
    bit            e_we;
    bit [AW-1:0]   e_addr;
    bit [DW-1:0]   e_wd;
    // Debug goes first unless it already used up its burst against a waiting CPU.
    dw_ = bus.dbg_req && (!bus.cpu_req || !m_last_dbg || m_streak < MAX_BURST);
    cw_ = bus.cpu_req && !dw_;
    e_we = 0; e_addr = '0; e_wd = '0;
    if (cw_) begin e_we = bus.cpu_we; e_addr = bus.cpu_addr; e_wd = bus.cpu_wdata; end
    else if (dw_) begin e_we = bus.dbg_we; e_addr = bus.dbg_addr; e_wd = bus.dbg_wdata; end

    chk("cpu_stall", bus.cpu_stall, bus.cpu_req && !cw_);
    chk("dbg_gnt", bus.dbg_gnt, dw_);
    chk("mem_en", bus.mem_en, cw_ || dw_);
    chk("mem_we", bus.mem_we, e_we);
    chk("mem_addr", bus.mem_addr, e_addr);
    chk("mem_wdata", bus.mem_wdata, e_wd);
    chk("cpu_rvalid", bus.cpu_rvalid, m_pend == 1);
    chk("cpu_rdata", bus.cpu_rdata, (m_pend == 1) ? m_pend_dat : '0);
    chk("dbg_rvalid", bus.dbg_rvalid, m_pend == 2);
    chk("dbg_rdata", bus.dbg_rdata, (m_pend == 2) ? m_pend_dat : '0);

    if (bus.cpu_req && bus.dbg_req) m_last_dbg = dw_;
    if (!bus.cpu_req || cw_) m_streak = 0;
    else if (m_streak < MAX_BURST) m_streak++;
    m_pend = 0;
    if (cw_ || dw_) begin
      if (e_we) ref_mem[e_addr] = e_wd;
      else begin
        m_pend     = cw_ ? 1 : 2;
        m_pend_dat = ref_mem[e_addr];
      end
    end
    m_cpu_hold = bus.cpu_req && !cw_;
    m_dbg_hold = bus.dbg_req && !dw_;
  endtask

  task automatic drive(input int cr, input int cw, input int ca, input int cd,
                       input int dr, input int dw, input int da, input int dd);
    bus.cpu_req   = cr[0];
    bus.cpu_we    = cw[0];
    bus.cpu_addr  = ca[AW-1:0];
    bus.cpu_wdata = cd;
    bus.dbg_req   = dr[0];
    bus.dbg_we    = dw[0];
    bus.dbg_addr  = da[AW-1:0];
    bus.dbg_wdata = dd;
  endtask

  task automatic cycle();
    @(negedge clk);
    model_step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    int cr, cw, ca, cd, dr, dw, da, dd;
    int xs, xg, xcv, xcd, xdv, xdd;
  } vec_t;
  vec_t vt[$];

  task automatic add(input int cr, input int cw, input int ca, input int cd,
                     input int dr, input int dw, input int da, input int dd,
                     input int xs, input int xg, input int xcv, input int xcd,
                     input int xdv, input int xdd);
    vec_t v;
    v.cr = cr; v.cw = cw; v.ca = ca; v.cd = cd;
    v.dr = dr; v.dw = dw; v.da = da; v.dd = dd;
    v.xs = xs; v.xg = xg; v.xcv = xcv; v.xcd = xcd; v.xdv = xdv; v.xdd = xdd;
    vt.push_back(v);
  endtask

  initial begin
    #5_000_000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    int vals [10];
    vals = '{20, 50, 10, 30, 70, 40, 60, 80, 100, 90};

    // Loader fill, loader read-back, uncontested CPU load, contested run, store/read race.
    for (int i = 0; i < 10; i++) add(0,0,0,0, 1,1,100+i,vals[i], 0,1, 0,0, 0,0);
    for (int i = 0; i < 10; i++)
      add(0,0,0,0, 1,0,100+i,0, 0,1, 0,0, (i > 0) ? 1 : 0, (i > 0) ? vals[i-1] : 0);
    add(0,0,0,0, 0,0,0,0, 0,0, 0,0, 1,vals[9]);
    add(1,0,102,0, 0,0,0,0, 0,0, 0,0, 0,0);
    add(0,0,0,0, 0,0,0,0, 0,0, 1,10, 0,0);
    for (int i = 0; i < 10; i++)
      add(1,0,103,0, 1,0,104,0, (i % 5 != 4) ? 1 : 0, (i % 5 != 4) ? 1 : 0,
          (i == 5) ? 1 : 0, (i == 5) ? 30 : 0,
          (i > 0 && i != 5) ? 1 : 0, (i > 0 && i != 5) ? 70 : 0);
    for (int j = 0; j < 5; j++)
      add(1,1,105,55, 1,0,105,0, (j < 4) ? 1 : 0, (j < 4) ? 1 : 0,
          (j == 0) ? 1 : 0, (j == 0) ? 30 : 0, (j >= 1) ? 1 : 0, (j >= 1) ? 40 : 0);
    add(0,0,0,0, 1,0,105,0, 0,1, 0,0, 0,0);
    add(0,0,0,0, 0,0,0,0, 0,0, 0,0, 1,55);

    drive(0,0,0,0, 0,0,0,0);
    model_reset();
    #2;
    chk("reset_cpu_rvalid", bus.cpu_rvalid, 0);
    chk("reset_dbg_rvalid", bus.dbg_rvalid, 0);
    chk("reset_cpu_rdata", bus.cpu_rdata, 0);
    chk("reset_dbg_rdata", bus.dbg_rdata, 0);
    chk("reset_mem_en", bus.mem_en, 0);
    #10;
    reset = 1'b1;
    @(posedge clk);
    #1;

    for (int k = 0; k < vt.size(); k++) begin
      drive(vt[k].cr, vt[k].cw, vt[k].ca, vt[k].cd, vt[k].dr, vt[k].dw, vt[k].da, vt[k].dd);
      @(negedge clk);
      chk($sformatf("vec%0d_stall", k), bus.cpu_stall, vt[k].xs);
      chk($sformatf("vec%0d_gnt", k), bus.dbg_gnt, vt[k].xg);
      chk($sformatf("vec%0d_cpu_rvalid", k), bus.cpu_rvalid, vt[k].xcv);
      chk($sformatf("vec%0d_cpu_rdata", k), bus.cpu_rdata, vt[k].xcd);
      chk($sformatf("vec%0d_dbg_rvalid", k), bus.dbg_rvalid, vt[k].xdv);
      chk($sformatf("vec%0d_dbg_rdata", k), bus.dbg_rdata, vt[k].xdd);
      model_step();
      @(posedge clk);
      #1;
    end

    // Reset while a CPU read is returning and while a debug read is being granted.
    drive(1,0,102,0, 0,0,0,0);
    cycle();
    chk("pre_rst_cpu_rvalid", bus.cpu_rvalid, 1);
    drive(0,0,0,0, 1,0,101,0);
    reset = 1'b0;
    #1;
    chk("rst_cpu_rvalid", bus.cpu_rvalid, 0);
    chk("rst_cpu_rdata", bus.cpu_rdata, 0);
    chk("rst_dbg_rvalid", bus.dbg_rvalid, 0);
    chk("rst_dbg_rdata", bus.dbg_rdata, 0);
    chk("rst_comb_gnt", bus.dbg_gnt, 1);
    chk("rst_comb_mem_en", bus.mem_en, 1);
    @(posedge clk);
    #1;
    chk("rst_dropped_rvalid", bus.dbg_rvalid, 0);
    reset = 1'b1;
    drive(0,0,0,0, 0,0,0,0);
    model_reset();
    @(negedge clk);
    chk("post_rst_mem_en", bus.mem_en, 0);
    chk("post_rst_dbg_rvalid", bus.dbg_rvalid, 0);
    model_step();
    @(posedge clk);
    #1;

`ifdef DMEM_ARB_STATS_EN
    drive(1,0,103,0, 1,0,104,0);
    for (int i = 0; i < 10; i++) cycle();
    drive(0,0,0,0, 0,0,0,0);
    cycle();
    chk("stat_stall_10", stat_stall, 8);
    chk("stat_dbg_10", stat_dbg, 8);
    drive(0,0,0,0, 1,0,104,0);
    for (int i = 0; i < 65540; i++) cycle();
    chk("stat_dbg_sat", stat_dbg, 16'hFFFF);
    chk("stat_stall_hold", stat_stall, 8);
    drive(0,0,0,0, 0,0,0,0);
    cycle();
`endif

    // Random traffic over a small address window so reads hit earlier writes.
    for (int n = 0; n < 600; n++) begin
      if (!m_cpu_hold) begin
        bus.cpu_req   = ($urandom_range(0, 99) < 60);
        bus.cpu_we    = $urandom_range(0, 1) == 1;
        bus.cpu_addr  = AW'(100 + $urandom_range(0, 7));
        bus.cpu_wdata = $urandom;
      end
      if (!m_dbg_hold) begin
        bus.dbg_req   = ($urandom_range(0, 99) < 70);
        bus.dbg_we    = $urandom_range(0, 1) == 1;
        bus.dbg_addr  = AW'(100 + $urandom_range(0, 7));
        bus.dbg_wdata = $urandom;
      end
      cycle();
    end
    drive(0,0,0,0, 0,0,0,0);
    cycle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port data memory between two requesters: the CPU datapath load/store port and a debug/DMA loader port.
- The loader preloads arrays (e.g. ten words at 100..109) and reads back results while the processor runs, replacing hierarchical backdoor writes.
- Sits between the datapath and the dmem instance.
- Resolves conflicts, stalls the CPU when it loses, and returns read data with fixed latency.

Parameters:
- AW, 10, word-address width of data memory.
- DW, 32, data width.
- MAX_BURST, 4, max consecutive debug grants while the CPU is requesting (1..15).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- cpu_req  in  1  CPU memory access request this cycle.
- cpu_we  in  1  1 = store, 0 = load.
- cpu_addr  in  AW  CPU word address.
- cpu_wdata  in  DW  CPU store data.
- cpu_stall  out  1  CPU request not granted this cycle; hold the request.
- cpu_rvalid  out  1  cpu_rdata valid (cycle after a granted load).
- cpu_rdata  out  DW  load data.
- dbg_req  in  1  debug access request.
- dbg_we  in  1  1 = write, 0 = read.
- dbg_addr  in  AW  debug word address.
- dbg_wdata  in  DW  debug write data.
- dbg_gnt  out  1  debug request accepted this cycle.
- dbg_rvalid  out  1  dbg_rdata valid.
- dbg_rdata  out  DW  debug read data.
- mem_en  out  1  memory access enable.
- mem_we  out  1  memory write enable.
- mem_addr  out  AW  memory address.
- mem_wdata  out  DW  memory write data.
- mem_rdata  in  DW  memory read data, valid 1 cycle after a read enable (synchronous read).

Behaviour:
- State: `last_dbg` (1b, last contested winner), `burst_cnt` (4b), `rsel` (2b: none/cpu/dbg, pending read owner).
- Grant is combinational from requests and registered state:
  - Only one requester active -> it wins.
  - Both active -> dbg wins iff `last_dbg`=0, or (`last_dbg`=1 and `burst_cnt` < MAX_BURST); otherwise cpu wins.
- `burst_cnt` update:
  - Increments on each dbg grant while cpu_req=1.
  - Clears on any cpu grant or any cycle with cpu_req=0.
  - Saturates at MAX_BURST.
- `last_dbg` update: set on a contested dbg grant; cleared on a contested cpu grant; unchanged otherwise.
- Memory outputs:
  - mem_en=1 whenever any grant occurs.
  - mem_we/addr/wdata are muxed from the winner.
  - With no request: mem_en=0, mem_we=0, addr/wdata=0.
- Grant signals: cpu_stall = cpu_req & ~cpu_grant; dbg_gnt = dbg grant.
- Read return:
  - A granted read sets `rsel` to its owner for the next cycle.
  - Next cycle, owner rvalid=1 and its rdata = mem_rdata.
  - Non-owner rdata holds 0; rvalid=0 after writes.
- Write latency: the write commits at the grant edge.
- Latency figures:
  - Uncontested read: 1 cycle.
  - Contested CPU worst-case wait: MAX_BURST cycles.
- Reset (async, any time, including mid-burst or with a read pending):
  - `last_dbg`=0, `burst_cnt`=0, `rsel`=none.
  - cpu_rvalid=0, dbg_rvalid=0, cpu_rdata=0, dbg_rdata=0.
  - Combinational outputs follow the inputs; a pending read is dropped, with no rvalid after release.
- Simultaneous new grant and read return: allowed (back-to-back reads pipeline, one per cycle).
- Requesters must hold req/addr/data stable while stalled/ungranted; the arbiter does not latch them.

Optional Feature:
- `DMEM_ARB_STATS_EN` defined adds two outputs:
  - stat_stall (16b): saturating count of cycles with cpu_stall=1.
  - stat_dbg (16b): saturating count of dbg grants.
  - Both cleared by reset.
- Undefined: ports and counters absent; behaviour otherwise identical.

Decomposition:
- Shared package `dmem_arb_pkg`: rsel encoding constants (RSEL_NONE=0, RSEL_CPU=1, RSEL_DBG=2) and default widths AW/DW.
- One sub-module is natural: `rr_burst_pick` (combinational grant plus `last_dbg`/`burst_cnt` registers).
- Muxing and read-return logic stay in the top level.

Test Plan:
- Reset low mid-operation -> all rvalid/rdata 0 on the same edge; after release, idle with no reqs -> mem_en=0.
- dbg writes 20,50,10,30,70,40,60,80,100,90 to 100..109, cpu idle -> dbg_gnt=1 each cycle; dbg reads back each value with dbg_rvalid 1 cycle after its grant.
- cpu load addr 102 uncontested -> cpu_stall=0, next cycle cpu_rvalid=1, cpu_rdata=10.
- cpu_req and dbg_req held continuously, MAX_BURST=4, `last_dbg`=0 at start -> grants dbg,dbg,dbg,dbg,cpu,dbg,dbg,dbg,dbg,cpu; cpu_stall high 4 of every 5 cycles.
- cpu store 55 to 105 and dbg read 105 in the same cycle, cpu wins -> dbg reads 55 the cycle after its grant.
- `DMEM_ARB_STATS_EN` build, contested 10-cycle run -> stat_stall=8, stat_dbg=8; saturation forced -> holds 0xFFFF.
